// File: rtl/spi_ram_if.sv
// Frame/response bus between the SPI slave (master modport) and the
// command-decoding RAM controller (slave modport).
interface spi_ram_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_valid;
    logic [DATA_WIDTH+1:0] rx_data;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  busy;

    modport master (output rx_valid, rx_data, input tx_valid, tx_data, busy);
    modport slave  (input rx_valid, rx_data, output tx_valid, tx_data, busy);
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind the SPI slave: edge-detects rx frames,
// executes addr/data commands and holds read responses for TX_HOLD cycles.
module spi_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TX_HOLD    = 8,
    parameter bit AUTO_INC   = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    spi_ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    typedef enum logic {IDLE, TX_RESP} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [CW-1:0]         cnt;
    logic                  rx_valid_d;
    state_t                state;

    logic                  frame;
    logic [1:0]            cmd;
    logic [DATA_WIDTH-1:0] payload;

    // A level held for many cycles must execute only once.
    assign frame   = bus.rx_valid & ~rx_valid_d;
    assign cmd     = bus.rx_data[DATA_WIDTH+1:DATA_WIDTH];
    assign payload = bus.rx_data[DATA_WIDTH-1:0];

    // Memory contents survive reset, so it lives outside the reset block.
    always_ff @(posedge clk) begin
        if (frame && cmd == 2'b01)
            mem[wr_addr] <= payload;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
            bus.busy     <= 1'b0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            rx_valid_d   <= 1'b0;
            cnt          <= '0;
        end else begin
            rx_valid_d <= bus.rx_valid;

            if (state == TX_RESP) begin
                if (cnt == '0) begin
                    state        <= IDLE;
                    bus.tx_valid <= 1'b0;
                    bus.busy     <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end

            // A new read overrides the expiry above, giving a gapless restart.
            if (frame) begin
                case (cmd)
                    2'b00: wr_addr <= payload[ADDR_WIDTH-1:0];
                    2'b01: if (AUTO_INC) wr_addr <= wr_addr + 1'b1;
                    2'b10: rd_addr <= payload[ADDR_WIDTH-1:0];
                    default: begin
                        bus.tx_data  <= mem[rd_addr];
                        bus.tx_valid <= 1'b1;
                        bus.busy     <= 1'b1;
                        cnt          <= CW'(TX_HOLD - 1);
                        state        <= TX_RESP;
                        if (AUTO_INC) rd_addr <= rd_addr + 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Drives one frame stream into two controllers (AUTO_INC=0 and AUTO_INC=1)
// and compares each against an abstract per-cycle model.
module tb_spi_ram_ctrl;
    localparam int DW = 8;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst;
    logic rx_valid;
    logic [DW+1:0] rx_data;

    always #5 clk = ~clk;

    spi_ram_if #(.DATA_WIDTH(DW)) if0 ();
    spi_ram_if #(.DATA_WIDTH(DW)) if1 ();
    assign if0.rx_valid = rx_valid;
    assign if0.rx_data  = rx_data;
    assign if1.rx_valid = rx_valid;
    assign if1.rx_data  = rx_data;

    spi_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(8), .TX_HOLD(HOLD), .AUTO_INC(1'b0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    spi_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(8), .TX_HOLD(HOLD), .AUTO_INC(1'b1))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, one slot per instance (index = AUTO_INC).
    logic [7:0] mem_m [2][256];
    logic [7:0] wa [2];
    logic [7:0] ra [2];
    logic [7:0] rdat [2];
    int         left [2];
    logic       prev_rx;
    int         hi_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            wa[k] = 8'h00; ra[k] = 8'h00; rdat[k] = 8'h00; left[k] = 0;
        end
        prev_rx = 1'b0;
    endtask

    task automatic model_edge();
        logic       acc;
        logic [1:0] c;
        logic [7:0] p;
        acc = rx_valid && !prev_rx;
        prev_rx = rx_valid;
        c = rx_data[DW+1:DW];
        p = rx_data[DW-1:0];
        for (int k = 0; k < 2; k++) begin
            if (left[k] > 0) left[k]--;
            if (acc) begin
                case (c)
                    2'd0: wa[k] = p;
                    2'd1: begin mem_m[k][wa[k]] = p; if (k == 1) wa[k] = wa[k] + 8'd1; end
                    2'd2: ra[k] = p;
                    default: begin
                        rdat[k] = mem_m[k][ra[k]];
                        left[k] = HOLD;
                        if (k == 1) ra[k] = ra[k] + 8'd1;
                    end
                endcase
            end
        end
    endtask

    task automatic compare_all();
        chk("inst0 tx_valid", 32'(if0.tx_valid), 32'(left[0] > 0));
        chk("inst0 busy",     32'(if0.busy),     32'(left[0] > 0));
        chk("inst1 tx_valid", 32'(if1.tx_valid), 32'(left[1] > 0));
        chk("inst1 busy",     32'(if1.busy),     32'(left[1] > 0));
        if (left[0] > 0) chk("inst0 tx_data", 32'(if0.tx_data), 32'(rdat[0]));
        if (left[1] > 0) chk("inst1 tx_data", 32'(if1.tx_data), 32'(rdat[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (if1.tx_valid) hi_cnt++;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] p, input int hi, input int lo);
        rx_valid = 1'b1;
        rx_data  = {c, p};
        repeat (hi) tick();
        rx_valid = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        model_reset();
        #1;
        chk("reset tx_valid0", 32'(if0.tx_valid), 32'd0);
        chk("reset tx_data0",  32'(if0.tx_data),  32'd0);
        chk("reset busy1",     32'(if1.busy),     32'd0);
        chk("reset tx_data1",  32'(if1.tx_data),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fill every location so all later reads are defined.
        for (int a = 0; a < 256; a++) begin
            send(2'd0, 8'(a), 1, 1);
            send(2'd1, 8'($urandom), 1, 1);
        end

        // Write 0xA5 to 0x10 with long frames, then read it back.
        send(2'd0, 8'h10, 5, 1);
        send(2'd1, 8'hA5, 5, 1);
        send(2'd2, 8'h10, 5, 1);
        send(2'd3, 8'h00, 2, 10);
        chk("read 0x10 value", 32'(mem_m[0][8'h10]), 32'h0000_00A5);

        // Level vs edge at the wrap point.
        send(2'd0, 8'hFF, 1, 1);
        send(2'd1, 8'h3C, 20, 1);
        send(2'd1, 8'h5A, 1, 1);
        send(2'd2, 8'hFF, 1, 1);
        send(2'd3, 8'h00, 1, 10);
        send(2'd2, 8'h00, 1, 1);
        send(2'd3, 8'h00, 1, 10);

        // Back-to-back read restarting 3 cycles in: continuous 3+8 high time.
        send(2'd0, 8'h20, 1, 1);
        send(2'd1, 8'h11, 1, 1);
        send(2'd0, 8'h21, 1, 1);
        send(2'd1, 8'h22, 1, 1);
        send(2'd2, 8'h20, 1, 1);
        hi_cnt = 0;
        send(2'd3, 8'h00, 2, 1);
        send(2'd3, 8'h00, 1, 12);
        chk("back-to-back high time", 32'(hi_cnt), 32'd11);

        // Write to the address under response; tx_data must stay frozen.
        send(2'd0, 8'h40, 1, 1);
        send(2'd2, 8'h40, 1, 1);
        send(2'd3, 8'h00, 1, 1);
        send(2'd1, 8'h77, 1, 10);
        send(2'd2, 8'h40, 1, 1);
        send(2'd3, 8'h00, 1, 10);

        // Asynchronous reset mid-response.
        send(2'd2, 8'h10, 1, 1);
        send(2'd3, 8'h00, 1, 2);
        rst = 1'b1;
        #1;
        chk("async rst tx_valid0", 32'(if0.tx_valid), 32'd0);
        chk("async rst busy0",     32'(if0.busy),     32'd0);
        chk("async rst tx_valid1", 32'(if1.tx_valid), 32'd0);
        chk("async rst busy1",     32'(if1.busy),     32'd0);
        rst = 1'b0;
        model_reset();
        send(2'd2, 8'h10, 1, 1);
        send(2'd3, 8'h00, 1, 10);

        // Randomized frame stream.
        for (int i = 0; i < 300; i++)
            send(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(1, 4), $urandom_range(1, 3));
        send(2'd3, 8'h00, 1, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
